// File: rtl/debug_response_tx.sv
// Debug link response transmitter: frames one response record as SYNC, CMD, LEN, payload (MSB first) [, CHECKSUM].
// Optional checksum byte enabled by defining DEBUG_TX_CHECKSUM_EN.
module debug_response_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 4
) (
    input  logic        comm_clock,
    input  logic        comm_reset,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [7:0]  resp_cmd,
    input  logic [2:0]  resp_len,
    input  logic [31:0] resp_payload,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy
);

    localparam logic [2:0] MAX_LEN_C = 3'(MAX_LEN);

`ifdef DEBUG_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, CMD, LEN, PAYLOAD, CHECKSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, CMD, LEN, PAYLOAD} state_t;
`endif

    state_t      state, state_next;
    logic [7:0]  cmd_r;
    logic [2:0]  len_r;
    logic [31:0] payload_r;
    logic [2:0]  cnt_r;
    logic [2:0]  len_clamped;
    logic [7:0]  pay_byte;
    logic        accept;
    logic        fire;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0]  sum_r;
`endif

    assign resp_ready  = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = resp_valid && resp_ready;
    assign fire        = out_valid && out_ready;
    assign len_clamped = (resp_len > MAX_LEN_C) ? MAX_LEN_C : resp_len;

    // cnt_r counts down from len, so it also indexes the next byte to send
    always_comb begin
        pay_byte = '0;
        case (cnt_r)
            3'd1:    pay_byte = payload_r[7:0];
            3'd2:    pay_byte = payload_r[15:8];
            3'd3:    pay_byte = payload_r[23:16];
            3'd4:    pay_byte = payload_r[31:24];
            default: pay_byte = '0;
        endcase
    end

    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            state     <= IDLE;
            cmd_r     <= '0;
            len_r     <= '0;
            payload_r <= '0;
            cnt_r     <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            sum_r     <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                cmd_r     <= resp_cmd;
                len_r     <= len_clamped;
                payload_r <= resp_payload;
                cnt_r     <= len_clamped;
`ifdef DEBUG_TX_CHECKSUM_EN
                sum_r     <= '0;
`endif
            end else if (fire) begin
                if (state == PAYLOAD && cnt_r != '0)
                    cnt_r <= cnt_r - 3'd1;
`ifdef DEBUG_TX_CHECKSUM_EN
                if (state == CMD || state == LEN || state == PAYLOAD)
                    sum_r <= sum_r + out_data;
`endif
            end
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                if (resp_valid)
                    state_next = SYNC;
            end
            SYNC: begin
                out_valid = 1'b1;
                out_data  = SYNC_BYTE;
                if (out_ready)
                    state_next = CMD;
            end
            CMD: begin
                out_valid = 1'b1;
                out_data  = cmd_r;
                if (out_ready)
                    state_next = LEN;
            end
            LEN: begin
                out_valid = 1'b1;
                out_data  = {5'b0, len_r};
                if (out_ready) begin
                    if (len_r != '0)
                        state_next = PAYLOAD;
                    else
`ifdef DEBUG_TX_CHECKSUM_EN
                        state_next = CHECKSUM;
`else
                        state_next = IDLE;
`endif
                end
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = pay_byte;
                if (out_ready && cnt_r <= 3'd1)
`ifdef DEBUG_TX_CHECKSUM_EN
                    state_next = CHECKSUM;
`else
                    state_next = IDLE;
`endif
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            CHECKSUM: begin
                out_valid = 1'b1;
                out_data  = ~sum_r + 8'd1;
                if (out_ready)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule
